// File: rtl/clkdiv_sel_arbiter.sv
// Two-requester arbiter that owns the clock divider select bus and applies
// new values glitch-safely: only while the divided clock is low, or on timeout.
module clkdiv_sel_arbiter #(
  parameter logic [4:0]  SEL_RESET     = 5'd9,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned WAIT_MAX      = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [4:0] sel0,
  output logic       ack0,
  input  logic       req1,
  input  logic [4:0] sel1,
  output logic       ack1,
  input  logic       clk_out_fb,
  output logic [4:0] sel_out,
  output logic       busy,
  output logic       timed_out
);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, SETTLE, ACK} state_e;

  localparam logic [15:0] WAIT_LAST   = 16'(WAIT_MAX - 1);
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0]  SEL_MAX     = 5'd23;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic [4:0]  lat_sel_q, lat_sel_d;
  logic [4:0]  sel_out_q, sel_out_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic        to_flag_q, to_flag_d;
  logic        ptr_q, ptr_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        busy_q, busy_d;
  logic        timed_out_q, timed_out_d;

  logic        win_id;
  logic [4:0]  win_raw;
  logic [4:0]  win_sel;

  // The pointer only matters when both requesters are active at once.
  assign win_id  = (req0 && req1) ? ptr_q : req1;
  assign win_raw = win_id ? sel1 : sel0;
  assign win_sel = (win_raw > SEL_MAX) ? SEL_MAX : win_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      lat_sel_q    <= '0;
      sel_out_q    <= SEL_RESET;
      wait_cnt_q   <= '0;
      settle_cnt_q <= '0;
      to_flag_q    <= 1'b0;
      ptr_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      lat_sel_q    <= lat_sel_d;
      sel_out_q    <= sel_out_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      to_flag_q    <= to_flag_d;
      ptr_q        <= ptr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      timed_out_q  <= timed_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    lat_sel_d    = lat_sel_q;
    sel_out_d    = sel_out_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;
    to_flag_d    = to_flag_q;
    ptr_d        = ptr_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d   = win_id;
          lat_sel_d = win_sel;
          to_flag_d = 1'b0;
          if (win_sel == sel_out_q) begin
            state_d = ACK;
          end else begin
            state_d    = WAIT_LOW;
            wait_cnt_d = '0;
          end
        end
      end
      WAIT_LOW: begin
        // Forcing with the feedback still high is the only way sel can move mid-pulse.
        if (!clk_out_fb || (wait_cnt_q == WAIT_LAST)) begin
          sel_out_d    = lat_sel_q;
          to_flag_d    = clk_out_fb;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = SETTLE;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = ACK;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      ACK: begin
        ptr_d     = ~grant_q;
        to_flag_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state flops.
  always_comb begin
    busy_d      = (state_d != IDLE);
    ack0_d      = (state_d == ACK) && !grant_d;
    ack1_d      = (state_d == ACK) && grant_d;
    timed_out_d = (state_d == ACK) && to_flag_d;
  end

  assign sel_out   = sel_out_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign timed_out = timed_out_q;

endmodule
